// File: rtl/router_if.sv
// Source/FIFO-side signal bundle for the router input controller.
// The master side drives the source stream and FIFO status; the slave side is the controller.
interface router_if;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       busy;
    logic [2:0] write_enb;
    logic [7:0] out_data;
    logic       parity_done;
    logic       err;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
        input  busy, write_enb, out_data, parity_done, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
        output busy, write_enb, out_data, parity_done, err
    );
endinterface

// File: rtl/router_ctrl.sv
// Router input-side sequencer: decodes the header, waits for the target FIFO to drain,
// forwards header/payload/parity into it and checks parity and length.
module router_ctrl (
    input  logic    clock,
    input  logic    resetn,
    router_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_EMPTY, LOAD_DATA, CHECK, DROP} state_t;

    state_t     state, state_nxt;
    logic [1:0] dest;
    logic [5:0] len, cnt;
    logic [7:0] hdr, par;
    logic       ovf, par_bad;

    logic [2:0] write_enb_q;
    logic [7:0] out_data_q;
    logic       parity_done_q, err_q;

    logic       busy, accept, abort;
    logic       hdr_ok, dest_full, dest_empty;
    logic [3:0] full_pad, empty_pad, sreset_pad;
    logic [2:0] dest_oh;

    // dest never holds 3 (only valid headers load it); padding keeps the index in range.
    assign full_pad   = {1'b0, bus.fifo_full};
    assign empty_pad  = {1'b0, bus.fifo_empty};
    assign sreset_pad = {1'b0, bus.soft_reset};
    assign dest_full  = full_pad[dest];
    assign dest_empty = empty_pad[dest];
    assign dest_oh    = 3'b001 << dest;
    assign hdr_ok     = (bus.data_in[1:0] != 2'd3);

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.pkt_valid) state_nxt = hdr_ok ? WAIT_EMPTY : DROP;
            WAIT_EMPTY: if (abort)           state_nxt = DROP;
                        else if (dest_empty) state_nxt = LOAD_DATA;
            LOAD_DATA:  if (abort)                          state_nxt = DROP;
                        else if (accept && !bus.pkt_valid) state_nxt = CHECK;
            CHECK:      state_nxt = IDLE;
            DROP:       if (accept && !bus.pkt_valid) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        accept = 1'b0;
        abort  = 1'b0;
        case (state)
            IDLE:       accept = bus.pkt_valid;
            WAIT_EMPTY: begin
                busy  = 1'b1;
                abort = sreset_pad[dest];
            end
            LOAD_DATA:  begin
                busy   = dest_full;
                accept = !dest_full;
                abort  = sreset_pad[dest];
            end
            CHECK:      busy = 1'b1;
            DROP:       accept = 1'b1;
            default:    busy = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            dest          <= '0;
            len           <= '0;
            hdr           <= '0;
            cnt           <= '0;
            par           <= '0;
            ovf           <= 1'b0;
            par_bad       <= 1'b0;
            write_enb_q   <= '0;
            out_data_q    <= '0;
            parity_done_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            write_enb_q   <= '0;
            parity_done_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (hdr_ok) begin
                        hdr     <= bus.data_in;
                        dest    <= bus.data_in[1:0];
                        len     <= bus.data_in[7:2];
                        par     <= bus.data_in;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                        par_bad <= 1'b0;
                        err_q   <= 1'b0;
                    end else begin
                        err_q   <= 1'b1;
                    end
                end
                WAIT_EMPTY: if (!abort && dest_empty) begin
                    out_data_q  <= hdr;
                    write_enb_q <= dest_oh;
                end
                LOAD_DATA: if (!abort && accept) begin
                    out_data_q  <= bus.data_in;
                    write_enb_q <= dest_oh;
                    if (bus.pkt_valid) begin
                        par <= par ^ bus.data_in;
                        // Count saturates; a byte beyond 63 is only visible through ovf.
                        if (cnt == 6'd63) ovf <= 1'b1;
                        else              cnt <= cnt + 6'd1;
                    end else begin
                        par_bad <= (bus.data_in != par);
                    end
                end
                CHECK: begin
                    parity_done_q <= 1'b1;
                    err_q         <= par_bad | (cnt != len) | ovf;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.write_enb   = write_enb_q;
    assign bus.out_data    = out_data_q;
    assign bus.parity_done = parity_done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_router_ctrl.sv
// Bench for router_ctrl: directed scenarios plus randomized packets with random
// back-pressure, checked against a packet-level model of the expected FIFO writes.
module tb_router_ctrl;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [2:0] full_force = 3'b000;
  logic [2:0] full_rand = 3'b000;
  logic rand_en = 1'b0;
  int nchk = 0;
  int nfail = 0;
  int pd_cnt = 0;
  logic [10:0] wr_q[$];
  logic [10:0] exp_q[$];
  logic [7:0] pay_q[$];
  logic exp_err;

  router_if bus();
  router_ctrl dut (.clock(clock), .resetn(resetn), .bus(bus));

  assign bus.fifo_full = full_force | full_rand;
  always #5 clock = ~clock;

  // Monitor: every FIFO write and parity_done pulse, sampled mid-cycle.
  always @(negedge clock) begin
    full_rand = (rand_en && $urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
    if (bus.write_enb != 3'b000) wr_q.push_back({bus.write_enb, bus.out_data});
    if (bus.parity_done) pd_cnt++;
  end

  // Expected writes and err for a packet, from the packet's bytes alone.
  task automatic model_pkt(input logic [7:0] h, input logic [7:0] p);
    logic [7:0] x;
    logic [2:0] oh;
    x = h;
    oh = 3'b001 << h[1:0];
    exp_q.delete();
    exp_q.push_back({oh, h});
    foreach (pay_q[i]) begin
      x ^= pay_q[i];
      exp_q.push_back({oh, pay_q[i]});
    end
    exp_q.push_back({oh, p});
    exp_err = (x != p) || (pay_q.size() != int'(h[7:2]));
  endtask

  function automatic int q_diff(input int start);
    if (wr_q.size() - start != exp_q.size()) return -2;
    foreach (exp_q[i]) if (wr_q[start + i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] xor_pay(input logic [7:0] h);
    logic [7:0] x;
    x = h;
    foreach (pay_q[i]) x ^= pay_q[i];
    return x;
  endfunction

  // Present a byte and hold it until the controller takes it (at the next unbusy edge).
  task automatic send_byte(input logic [7:0] b, input logic v);
    int guard;
    guard = 0;
    bus.data_in = b;
    bus.pkt_valid = v;
    #1;
    while (bus.busy && guard < 200) begin
      @(negedge clock);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      nchk++;
      nfail++;
      $display("FAIL send_byte_timeout: busy still %b after 200 cycles, required 0", bus.busy);
    end
    @(negedge clock);
  endtask

  task automatic drive_pkt(input logic [7:0] h, input logic [7:0] p);
    int pd0;
    int guard;
    pd0 = pd_cnt;
    guard = 0;
    send_byte(h, 1'b1);
    foreach (pay_q[i]) send_byte(pay_q[i], 1'b1);
    send_byte(p, 1'b0);
    bus.pkt_valid = 1'b0;
    while (pd_cnt == pd0 && guard < 20) begin
      @(negedge clock);
      #1;
      guard++;
    end
    nchk++;
    if (pd_cnt == pd0) begin
      nfail++;
      $display("FAIL pkt_done_timeout hdr=%h: parity_done count %0d, required %0d", h, pd_cnt, pd0 + 1);
    end
    repeat (2) @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    nchk++;
    if ({bus.write_enb, bus.out_data, bus.parity_done, bus.err, bus.busy} !== 14'd0) begin
      nfail++;
      $display("FAIL reset_outputs: we=%b od=%h pd=%b err=%b busy=%b, required all 0",
               bus.write_enb, bus.out_data, bus.parity_done, bus.err, bus.busy);
    end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int start, pd0, d;
    start = wr_q.size();
    pd0 = pd_cnt;
    pay_q = {8'h11, 8'h22, 8'h33};
    model_pkt(8'h0D, 8'h0D);
    drive_pkt(8'h0D, 8'h0D);
    d = q_diff(start);
    nchk++;
    if (d != -1) begin
      nfail++;
      $display("FAIL basic_writes: diff at %0d, got %0d writes, required %0d", d, wr_q.size() - start, exp_q.size());
    end
    nchk++;
    if (pd_cnt - pd0 != 1) begin
      nfail++;
      $display("FAIL basic_parity_done: got %0d pulses, required 1", pd_cnt - pd0);
    end
    nchk++;
    if (bus.err !== 1'b0) begin
      nfail++;
      $display("FAIL basic_err: got %b, required 0", bus.err);
    end
  endtask

  task automatic test_wait_empty();
    int start;
    logic [7:0] pb;
    pb = 8'($urandom);
    start = wr_q.size();
    bus.fifo_empty = 3'b011;
    send_byte(8'h06, 1'b1);
    bus.data_in = pb;
    bus.pkt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      nchk++;
      if (bus.busy !== 1'b1) begin
        nfail++;
        $display("FAIL wait_busy cycle %0d: got %b, required 1", i, bus.busy);
      end
      @(negedge clock);
    end
    nchk++;
    if (wr_q.size() != start) begin
      nfail++;
      $display("FAIL wait_early_write: got %0d writes, required 0", wr_q.size() - start);
    end
    bus.fifo_empty = 3'b111;
    @(negedge clock);
    nchk++;
    if (bus.write_enb !== 3'b100 || bus.out_data !== 8'h06) begin
      nfail++;
      $display("FAIL wait_hdr_write: we=%b od=%h, required 100/06", bus.write_enb, bus.out_data);
    end
    send_byte(pb, 1'b1);
    send_byte(8'h06 ^ pb, 1'b0);
    bus.pkt_valid = 1'b0;
    repeat (4) @(negedge clock);
    pay_q = {pb};
    model_pkt(8'h06, 8'h06 ^ pb);
    nchk++;
    if (q_diff(start) != -1 || bus.err !== 1'b0) begin
      nfail++;
      $display("FAIL wait_packet: diff=%0d err=%b, required -1/0", q_diff(start), bus.err);
    end
  endtask

  task automatic test_back_pressure();
    int start;
    logic [7:0] p0, p1, p2, par;
    p0 = 8'($urandom); p1 = 8'($urandom); p2 = 8'($urandom);
    par = 8'h0C ^ p0 ^ p1 ^ p2;
    start = wr_q.size();
    send_byte(8'h0C, 1'b1);
    send_byte(p0, 1'b1);
    bus.data_in = p1;
    bus.pkt_valid = 1'b1;
    full_force = 3'b001;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchk++;
      if (bus.busy !== 1'b1) begin
        nfail++;
        $display("FAIL bp_busy cycle %0d: got %b, required 1", i, bus.busy);
      end
      @(negedge clock);
      nchk++;
      if (bus.write_enb !== 3'b000) begin
        nfail++;
        $display("FAIL bp_no_write cycle %0d: got %b, required 000", i, bus.write_enb);
      end
    end
    full_force = 3'b000;
    #1;
    nchk++;
    if (bus.busy !== 1'b0) begin
      nfail++;
      $display("FAIL bp_release: busy %b, required 0", bus.busy);
    end
    send_byte(p1, 1'b1);
    send_byte(p2, 1'b1);
    send_byte(par, 1'b0);
    bus.pkt_valid = 1'b0;
    repeat (4) @(negedge clock);
    pay_q = {p0, p1, p2};
    model_pkt(8'h0C, par);
    nchk++;
    if (q_diff(start) != -1) begin
      nfail++;
      $display("FAIL bp_order: diff at %0d, required -1", q_diff(start));
    end
  endtask

  task automatic test_bad_parity();
    pay_q = {8'hAA};
    model_pkt(8'h05, 8'h00);
    drive_pkt(8'h05, 8'h00);
    nchk++;
    if (bus.err !== exp_err || exp_err !== 1'b1) begin
      nfail++;
      $display("FAIL badpar_err: got %b, required 1", bus.err);
    end
    repeat (3) @(negedge clock);
    nchk++;
    if (bus.err !== 1'b1) begin
      nfail++;
      $display("FAIL badpar_sticky: got %b, required 1", bus.err);
    end
    send_byte(8'h05, 1'b1);
    nchk++;
    if (bus.err !== 1'b0) begin
      nfail++;
      $display("FAIL badpar_clear: got %b, required 0", bus.err);
    end
    send_byte(8'hAA, 1'b1);
    send_byte(8'hAF, 1'b0);
    bus.pkt_valid = 1'b0;
    repeat (4) @(negedge clock);
    nchk++;
    if (bus.err !== 1'b0) begin
      nfail++;
      $display("FAIL badpar_good_after: got %b, required 0", bus.err);
    end
  endtask

  task automatic test_invalid_addr();
    int start, pd0, d;
    start = wr_q.size();
    pd0 = pd_cnt;
    send_byte(8'h07, 1'b1);
    nchk++;
    if (bus.err !== 1'b1) begin
      nfail++;
      $display("FAIL inval_err: got %b, required 1", bus.err);
    end
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hF8, 1'b0);
    bus.pkt_valid = 1'b0;
    @(negedge clock);
    #1;
    nchk++;
    if (wr_q.size() != start || pd_cnt != pd0 || bus.busy !== 1'b0) begin
      nfail++;
      $display("FAIL inval_drop: writes %0d pd %0d busy %b, required 0/0/0",
               wr_q.size() - start, pd_cnt - pd0, bus.busy);
    end
    start = wr_q.size();
    pay_q = {8'h11, 8'h22, 8'h33};
    model_pkt(8'h0D, 8'h0D);
    drive_pkt(8'h0D, 8'h0D);
    d = q_diff(start);
    nchk++;
    if (d != -1 || bus.err !== 1'b0) begin
      nfail++;
      $display("FAIL inval_next_pkt: diff %0d err %b, required -1/0", d, bus.err);
    end
  endtask

  task automatic test_soft_reset();
    int start, pd0, d;
    logic [7:0] pb[4];
    foreach (pb[i]) pb[i] = 8'($urandom);
    start = wr_q.size();
    pd0 = pd_cnt;
    send_byte(8'h11, 1'b1);
    bus.soft_reset = 3'b101;
    send_byte(pb[0], 1'b1);
    bus.soft_reset = 3'b000;
    send_byte(pb[1], 1'b1);
    bus.data_in = pb[2];
    bus.pkt_valid = 1'b1;
    bus.soft_reset = 3'b010;
    @(negedge clock);
    bus.soft_reset = 3'b000;
    send_byte(pb[3], 1'b1);
    send_byte(8'h5A, 1'b0);
    bus.pkt_valid = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    pay_q = {pb[0], pb[1]};
    model_pkt(8'h11, 8'h00);
    exp_q.pop_back();
    d = q_diff(start);
    nchk++;
    if (d != -1) begin
      nfail++;
      $display("FAIL sr_writes: diff %0d, got %0d writes, required 3", d, wr_q.size() - start);
    end
    nchk++;
    if (pd_cnt != pd0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      nfail++;
      $display("FAIL sr_status: pd %0d err %b busy %b, required 0/0/0", pd_cnt - pd0, bus.err, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int start;
    send_byte(8'h07, 1'b1);
    send_byte(8'h55, 1'b1);
    resetn = 1'b0;
    bus.data_in = 8'h66;
    @(negedge clock);
    nchk++;
    if ({bus.write_enb, bus.out_data, bus.parity_done, bus.err, bus.busy} !== 14'd0) begin
      nfail++;
      $display("FAIL reset_mid_drop: we=%b od=%h pd=%b err=%b busy=%b, required all 0",
               bus.write_enb, bus.out_data, bus.parity_done, bus.err, bus.busy);
    end
    resetn = 1'b1;
    bus.pkt_valid = 1'b0;
    @(negedge clock);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h11, 1'b1);
    resetn = 1'b0;
    @(negedge clock);
    nchk++;
    if ({bus.write_enb, bus.out_data, bus.parity_done, bus.err, bus.busy} !== 14'd0) begin
      nfail++;
      $display("FAIL reset_mid_load: we=%b od=%h pd=%b err=%b busy=%b, required all 0",
               bus.write_enb, bus.out_data, bus.parity_done, bus.err, bus.busy);
    end
    resetn = 1'b1;
    bus.pkt_valid = 1'b0;
    @(negedge clock);
    start = wr_q.size();
    pay_q = {8'h11, 8'h22, 8'h33};
    model_pkt(8'h0D, 8'h0D);
    drive_pkt(8'h0D, 8'h0D);
    nchk++;
    if (q_diff(start) != -1 || bus.err !== 1'b0) begin
      nfail++;
      $display("FAIL reset_mid_restart: diff %0d err %b, required -1/0", q_diff(start), bus.err);
    end
  endtask

  task automatic test_len_bounds();
    int ns[3];
    int start, pd0;
    logic [7:0] h, p;
    ns = '{0, 63, 64};
    for (int k = 0; k < 3; k++) begin
      h = (ns[k] == 0) ? 8'h00 : 8'hFE;
      pay_q.delete();
      repeat (ns[k]) pay_q.push_back(8'($urandom));
      p = xor_pay(h);
      start = wr_q.size();
      pd0 = pd_cnt;
      model_pkt(h, p);
      drive_pkt(h, p);
      nchk++;
      if (q_diff(start) != -1) begin
        nfail++;
        $display("FAIL len_writes n=%0d: diff %0d, required -1", ns[k], q_diff(start));
      end
      nchk++;
      if (bus.err !== exp_err || pd_cnt - pd0 != 1) begin
        nfail++;
        $display("FAIL len_err n=%0d: err %b pd %0d, required %b/1", ns[k], bus.err, pd_cnt - pd0, exp_err);
      end
    end
  endtask

  task automatic test_random();
    int start, pd0, len, n;
    logic [7:0] h, p;
    rand_en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      len = $urandom_range(0, 8);
      n = ($urandom_range(0, 7) == 0) ? len + 1 : len;
      h = {6'(len), 2'($urandom_range(0, 2))};
      pay_q.delete();
      repeat (n) pay_q.push_back(8'($urandom));
      p = xor_pay(h);
      if ($urandom_range(0, 3) == 0) p = p ^ 8'($urandom_range(1, 255));
      start = wr_q.size();
      pd0 = pd_cnt;
      model_pkt(h, p);
      drive_pkt(h, p);
      nchk++;
      if (q_diff(start) != -1) begin
        nfail++;
        $display("FAIL rand%0d_writes hdr=%h: diff %0d, got %0d writes, required %0d",
                 k, h, q_diff(start), wr_q.size() - start, exp_q.size());
      end
      nchk++;
      if (bus.err !== exp_err || pd_cnt - pd0 != 1) begin
        nfail++;
        $display("FAIL rand%0d_err hdr=%h: err %b pd %0d, required %b/1", k, h, bus.err, pd_cnt - pd0, exp_err);
      end
    end
    rand_en = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    bus.pkt_valid = 1'b0;
    bus.data_in = 8'h00;
    bus.fifo_empty = 3'b111;
    bus.soft_reset = 3'b000;
    test_reset();
    test_basic();
    test_wait_empty();
    test_back_pressure();
    test_bad_parity();
    test_invalid_addr();
    test_soft_reset();
    test_reset_mid();
    test_len_bounds();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/router_ctrl.md
# router_ctrl

Packet sequencing controller for the 1x3 router input side. It accepts a byte stream from the source, decodes the header, and waits for the addressed output FIFO to drain. It then forwards header, payload and parity bytes into the selected FIFO, pacing the source with `busy`. It computes running parity and packet length, and reports `err` and `parity_done` once the parity byte has been checked.

## Interface
- No parameters. Three output ports and 8-bit bytes are fixed.
- `clock` in 1: system clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `pkt_valid` in 1: high while header and payload bytes are on `data_in`; low on the cycle the parity byte is presented.
- `data_in` in 8: source byte. Header format is [7:2] payload length (0..63) and [1:0] destination (0..2; 3 is invalid).
- `fifo_full` in 3: per-port FIFO full.
- `fifo_empty` in 3: per-port FIFO empty.
- `soft_reset` in 3: per-port abort from the output-side timeout logic.
- `busy` out 1: source must hold `data_in` and `pkt_valid` while high. Combinational.
- `write_enb` out 3: one-hot FIFO write strobe, registered.
- `out_data` out 8: byte to FIFOs, registered. Valid when `write_enb` is nonzero.
- `parity_done` out 1: one-cycle pulse, registered.
- `err` out 1: sticky packet error, registered.

## Operation
- Internal registers:
  - `dest` (2b)
  - `len` (6b)
  - `hdr` (8b)
  - `cnt`: 6-bit received-payload count, saturates at 63; an overflow flag is set on a 64th byte.
  - `par` (8b, XOR accumulator)
- States: IDLE, WAIT_EMPTY, LOAD_DATA, CHECK, DROP.
- A byte is accepted in any cycle where `busy`=0 and the state is IDLE (with `pkt_valid`=1), LOAD_DATA or DROP.
- `busy` is 1 in WAIT_EMPTY and CHECK. In LOAD_DATA it equals `fifo_full[dest]`. It is 0 in IDLE and DROP.
- IDLE:
  - Waits for `pkt_valid`=1.
  - Header with `data_in[1:0]`≠3: load `hdr`, `dest`, `len`; set `par`=`data_in`, `cnt`=0, `err`=0; go to WAIT_EMPTY.
  - Header with addr=3: set `err`=1; go to DROP (header consumed).
- WAIT_EMPTY:
  - Stays until `fifo_empty[dest]`=1.
  - On that cycle: `out_data`←`hdr`, `write_enb`←onehot(`dest`), go to LOAD_DATA.
- LOAD_DATA, accepted byte with `pkt_valid`=1 (payload):
  - `out_data`←`data_in`, `write_enb`←onehot(`dest`).
  - `par`^=`data_in`, `cnt`++.
- LOAD_DATA, accepted byte with `pkt_valid`=0 (parity byte):
  - Written to the FIFO the same way.
  - Compared against `par`, and `cnt` against `len`; go to CHECK.
- CHECK:
  - `parity_done`←1.
  - `err`←(parity mismatch | `cnt`≠`len` | overflow).
  - Go to IDLE.
- DROP:
  - Accepts and discards bytes; no writes.
  - Returns to IDLE after accepting a byte with `pkt_valid`=0.
- `soft_reset[dest]`=1 in WAIT_EMPTY or LOAD_DATA:
  - Go to DROP next cycle.
  - No write that cycle.
  - `err` and `parity_done` are unchanged.
  - Bits of `soft_reset` for ports other than `dest` are ignored.
- `write_enb` is 0 in every cycle not listed above.
- `len`=0 is legal: the byte after the header is the parity byte.
- Reset (any state, mid-packet included):
  - State is IDLE.
  - `write_enb`=0, `out_data`=0, `parity_done`=0, `err`=0, `busy`=0.
  - Internal registers are 0.
  - The source must restart from a header.

## Timing
- Header accepted at cycle T. State is WAIT_EMPTY at T+1.
- If the FIFO is empty at T+1, the header write is visible at T+2 and the first payload byte can be accepted at T+2.
- Payload or parity byte accepted at cycle t: `write_enb` and `out_data` are visible at t+1.
- `fifo_full[dest]` rising at cycle t forces `busy`=1 in the same cycle. No byte is accepted until it falls.
- Parity accepted at t_p:
  - State is CHECK at t_p+1 (`busy`=1).
  - `parity_done` and `err` are visible at t_p+2.
  - The next header can be accepted at t_p+2.
- `err` holds until the next valid header is accepted or reset occurs.

## Test plan
- Basic packet to port 1:
  - Stimulus: header 0x0D, payload 0x11 0x22 0x33, parity 0x0D; FIFOs empty and not full.
  - Response: five writes with `write_enb`=3'b010 and `out_data` 0D,11,22,33,0D; `parity_done` pulses once; `err`=0.
- Wait for empty:
  - Stimulus: `fifo_empty[2]`=0, header 0x06; release `fifo_empty[2]` 4 cycles later.
  - Response: `busy`=1 for those cycles; header written 1 cycle after release; payload then accepted normally.
- Back-pressure:
  - Stimulus: `fifo_full[0]` high for 3 cycles mid-payload.
  - Response: `busy`=1 in exactly those cycles; no write, no byte lost; output byte order unchanged.
- Bad parity:
  - Stimulus: header 0x05 (len1, port1), payload 0xAA, parity 0x00.
  - Response: `err`=1 with `parity_done`; `err` held until the next valid header, then cleared.
- Invalid address:
  - Stimulus: header 0x07 followed by 2 payload bytes and a parity byte.
  - Response: `write_enb` never asserts; `err`=1; IDLE after the parity byte; the next packet is processed normally.
- Mid-packet aborts:
  - Stimulus: `soft_reset[1]` pulse during LOAD_DATA of a port-1 packet.
  - Response: no further writes; remaining bytes dropped; no `parity_done`.
  - Stimulus: `resetn`=0 mid-packet.
  - Response: all outputs 0 on the next cycle.
